// File: rtl/i2c_edge_filter.sv
// Multi-channel I2C line synchroniser and glitch filter with per-channel edge pulses.
// Optional macro I2C_COND_DETECT_EN adds START/STOP detection on channels 0 (SCL) and 1 (SDA).
module i2c_edge_filter #(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter bit IDLE_LEVEL    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] line_in,
  output logic [NUM_CH-1:0] line_out,
  output logic [NUM_CH-1:0] rising_edge_found,
  output logic [NUM_CH-1:0] falling_edge_found
`ifdef I2C_COND_DETECT_EN
  ,
  output logic              start_found,
  output logic              stop_found
`endif
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
  localparam logic [NUM_CH-1:0] IDLE_VEC = {NUM_CH{IDLE_LEVEL}};

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]     cnt    [NUM_CH];
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] toggle;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IDLE_VEC;
    end else begin
      sync_q[0] <= line_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A channel flips once its synchronised level has differed for FILTER_CYCLES samples.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      toggle[i] = (sync_out[i] != line_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_out           <= IDLE_VEC;
      rising_edge_found  <= '0;
      falling_edge_found <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (toggle[i]) begin
          line_out[i] <= ~line_out[i];
          cnt[i]      <= '0;
        end else if (sync_out[i] == line_out[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      // Direction is taken from the level being left, so rise and fall are exclusive.
      rising_edge_found  <= toggle & ~line_out;
      falling_edge_found <= toggle & line_out;
    end
  end

`ifdef I2C_COND_DETECT_EN
  // SDA moving while SCL is steadily high; a simultaneous SCL toggle is not a bus condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_found <= 1'b0;
      stop_found  <= 1'b0;
    end else begin
      start_found <= toggle[1] & line_out[1] & line_out[0] & ~toggle[0];
      stop_found  <= toggle[1] & ~line_out[1] & line_out[0] & ~toggle[0];
    end
  end
`endif

endmodule

// File: tb/tb_i2c_edge_filter.sv
// Directed bench for i2c_edge_filter at default parameters; START/STOP checks
// are compiled in when I2C_COND_DETECT_EN is defined.
module tb_i2c_edge_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] line_in = 2'b11;
  logic [1:0] line_out;
  logic [1:0] rising_edge_found;
  logic [1:0] falling_edge_found;
`ifdef I2C_COND_DETECT_EN
  logic       start_found;
  logic       stop_found;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  i2c_edge_filter dut (
    .clk                (clk),
    .rst                (rst),
    .line_in            (line_in),
    .line_out           (line_out),
    .rising_edge_found  (rising_edge_found),
    .falling_edge_found (falling_edge_found)
`ifdef I2C_COND_DETECT_EN
    ,
    .start_found        (start_found),
    .stop_found         (stop_found)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] drive;
    int         hold;
    int         p1_at;
    logic [1:0] p1_rise;
    logic [1:0] p1_fall;
    int         p2_at;
    logic [1:0] p2_rise;
    logic [1:0] p2_fall;
    logic [1:0] exp_out;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d] got=%b want=%b at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Drive a level just after an edge, then sample each following edge at +1.
  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] er, ef;
    line_in = v.drive;
    for (int j = 1; j <= v.hold; j++) begin
      @(posedge clk); #1;
      er = 2'b00;
      ef = 2'b00;
      if (j == v.p1_at) begin er = v.p1_rise; ef = v.p1_fall; end
      if (j == v.p2_at) begin er = v.p2_rise; ef = v.p2_fall; end
      check("rise", idx, rising_edge_found, er);
      check("fall", idx, falling_edge_found, ef);
      if ((er | ef) != 2'b00) check("out_at_pulse", idx, line_out & (er | ef), er);
    end
    check("out_end", idx, line_out, v.exp_out);
  endtask

`ifdef I2C_COND_DETECT_EN
  task automatic run_cond(input logic [1:0] drive, input int start_at, input int stop_at, input int idx);
    line_in = drive;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      check("start", idx, {1'b0, start_found}, {1'b0, j == start_at});
      check("stop",  idx, {1'b0, stop_found},  {1'b0, j == stop_at});
    end
  endtask
`endif

  initial begin
    //          drive  hold p1 rise   fall   p2 rise   fall   out
    vecs[0]  = '{2'b11, 30, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[1]  = '{2'b10, 10, 6, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b10};
    vecs[2]  = '{2'b11, 10, 6, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[3]  = '{2'b10,  3, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[4]  = '{2'b11, 10, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[5]  = '{2'b10,  4, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[6]  = '{2'b11, 12, 2, 2'b00, 2'b01, 6, 2'b01, 2'b00, 2'b11};
    vecs[7]  = '{2'b00, 10, 6, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{2'b11, 10, 6, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[9]  = '{2'b01, 10, 6, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b01};
    vecs[10] = '{2'b11, 10, 6, 2'b10, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[11] = '{2'b10,  2, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11};
    vecs[12] = '{2'b00, 10, 4, 2'b00, 2'b01, 6, 2'b00, 2'b10, 2'b00};
    vecs[13] = '{2'b11, 10, 6, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b11};

    // Reset: three cycles, idle outputs
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_out", c, line_out, 2'b11);
      check("rst_rise", c, rising_edge_found, 2'b00);
      check("rst_fall", c, falling_edge_found, 2'b00);
    end
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset arriving three cycles into a pending SCL fall discards it
    line_in = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("pre_rst_fall", 100 + c, falling_edge_found, 2'b00);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("mid_rst_out", 200 + c, line_out, 2'b11);
      check("mid_rst_rise", 200 + c, rising_edge_found, 2'b00);
      check("mid_rst_fall", 200 + c, falling_edge_found, 2'b00);
    end
    rst = 1'b0;
    run_vec('{2'b10, 10, 6, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b10}, 300);
    run_vec('{2'b11, 10, 6, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b11}, 301);

`ifdef I2C_COND_DETECT_EN
    run_cond(2'b01, 6, 0, 400);
    run_cond(2'b11, 0, 6, 401);
    run_cond(2'b00, 0, 0, 402);
    run_cond(2'b11, 0, 0, 403);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_edge_filter.md
I2C_EDGE_FILTER -- requirements
Module: i2c_edge_filter

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent line channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (>=2).
REQ-003 Parameter FILTER_CYCLES, default 4: consecutive stable synchronised samples needed to accept a level change (>=1).
REQ-004 Parameter IDLE_LEVEL, default 1: line level assumed in reset (I2C bus idle high).
REQ-005 clk  input  1  sole clock; all state updates on rising edge; one clock; reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 line_in  input  NUM_CH  raw asynchronous line levels (bit 0 = SCL, bit 1 = SDA by convention).
REQ-008 line_out  output  NUM_CH  filtered, registered line levels.
REQ-009 rising_edge_found  output  NUM_CH  one-cycle pulse per channel on accepted 0->1 change.
REQ-010 falling_edge_found  output  NUM_CH  one-cycle pulse per channel on accepted 1->0 change.
REQ-011 start_found, stop_found  output  1 each  one-cycle bus condition pulses; present only with I2C_COND_DETECT_EN.

Function
REQ-012 Each channel SHALL pass line_in through a SYNC_STAGES-deep flop chain; filter logic SHALL use only the last stage.
REQ-013 Per channel, a counter of width $clog2(FILTER_CYCLES+1) SHALL clear whenever the sync output equals line_out, and increment while it differs.
REQ-014 When the sync output differs and the counter equals FILTER_CYCLES-1, line_out SHALL toggle on that edge and the counter SHALL clear.
REQ-015 The edge pulse matching the toggle direction SHALL assert in the same cycle line_out first shows the new value, for exactly one cycle.
REQ-016 Latency: a line_in change stable from clock edge k SHALL appear on line_out and its pulse after edge k+SYNC_STAGES+FILTER_CYCLES-1.
REQ-017 A sync-output excursion shorter than FILTER_CYCLES cycles SHALL produce no line_out change and no pulse; the counter SHALL never exceed FILTER_CYCLES-1.
REQ-018 FILTER_CYCLES=1 SHALL accept every sync-output change on the first differing sample.
REQ-019 Rising and falling pulses of one channel SHALL never assert together; different channels SHALL be fully independent and may pulse in the same cycle.
REQ-020 Pulses SHALL be registered outputs with no combinational path from line_in.

Reset
REQ-021 While rst=1, all synchroniser flops and line_out SHALL load IDLE_LEVEL, counters load 0, and all pulse outputs (incl. start_found/stop_found) drive 0 from the next edge.
REQ-022 Reset asserted mid-filter SHALL discard the pending count; no pulse SHALL result from the discarded change.
REQ-023 After release, a line_in differing from IDLE_LEVEL SHALL be reported as a normal edge after REQ-016 latency.

Configuration
REQ-024 Macro I2C_COND_DETECT_EN: when defined (requires NUM_CH>=2), start_found SHALL pulse one cycle when channel 1 takes a falling edge while line_out[0] is 1 and channel 0 is not toggling that cycle; stop_found likewise on channel 1 rising edge.
REQ-025 Simultaneous accepted toggles of channels 0 and 1 SHALL produce neither start_found nor stop_found.
REQ-026 When the macro is undefined, start_found/stop_found and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (defaults, 10 ns clk)
REQ-027 rst 3 cycles, line_in=2'b11 for 30 cycles -> line_out=2'b11, all pulses 0 throughout.
REQ-028 line_in[0] 1->0 held -> falling_edge_found[0] single pulse after edge k+5, line_out[0]=0 same cycle; bit 1 no pulse.
REQ-029 line_in[0] low 3 cycles then high -> no pulse; low 4 cycles -> falling pulse, then rising pulse after the return.
REQ-030 line_in 2'b11->2'b00 same edge -> falling_edge_found=2'b11 in one cycle.
REQ-031 Macro defined: SCL=1, SDA 1->0 -> start_found one pulse; SDA 0->1 -> stop_found one pulse; both lines toggled same edge -> neither.
REQ-032 line_in[0]=0, rst asserted 3 cycles into filter -> no pulse, line_out=2'b11; after release falling pulse at REQ-016 latency.
